det_window_counter: RTL
=======================

Name: det_window_counter

Overview:
- Downstream consumer of the 101/110 Moore sequence detector.
- Takes the detector's 1-bit registered detection output and counts detections over a fixed window of clock cycles.
- At the end of each window it reports the count with a one-cycle valid strobe.
- It raises a sticky alarm when the count reaches a threshold, for status/interrupt logic.

Parameters:
- WIN_LEN, 16: window length in clock cycles; legal range 1..65536; window counter width is clog2(WIN_LEN), minimum 1.
- CNT_W, 5: width of the event counter and count_out.
- THRESH, 3: alarm threshold; legal range 1..2^CNT_W-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start/continue windows; sampled in IDLE and REPORT.
- det_in  in  1  detection output of the upstream Moore detector.
- count_out  out  CNT_W  event count of the last completed window; registered.
- count_valid  out  1  one-cycle strobe; count_out/alarm just updated.
- alarm  out  1  1 if the last reported count >= THRESH; registered.
- busy  out  1  1 while in WINDOW or REPORT.

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state=IDLE
  - count_out=0, count_valid=0, alarm=0, busy=0
  - internal window counter and event counter to 0
- rst has priority over all other inputs, including mid-window; a partial window is discarded and never reported.
- IDLE:
  - det_in is ignored.
  - en=1 at an edge moves to WINDOW, with win_cnt=0 and evt_cnt=0.
- WINDOW: lasts exactly WIN_LEN cycles. On each edge:
  - if det_in=1, evt_cnt increments, saturating at 2^CNT_W-1 (no wrap);
  - win_cnt increments.
  - The edge where win_cnt==WIN_LEN-1 samples det_in one last time (that sample counts), then moves to REPORT.
  - en is ignored in WINDOW; deasserting en does not abort the window.
- REPORT: exactly one cycle.
  - count_valid=1.
  - count_out shows the final evt_cnt, including the last window sample.
  - alarm = (final count >= THRESH).
  - det_in in this cycle is ignored, never counted.
  - At the edge ending REPORT: en=1 goes to WINDOW with counters cleared (back-to-back windows, period WIN_LEN+1 cycles); en=0 goes to IDLE.
- count_out and alarm hold their values between REPORT cycles. Only a new REPORT or rst changes them; alarm clears on a report below THRESH.
- busy=1 in WINDOW and REPORT, 0 in IDLE.
- Latency: count_valid rises in the cycle immediately after the last window cycle.
- Counting model: each cycle with det_in=1 is one detection. Consecutive high cycles are distinct detections, because the Moore detector can produce them back-to-back on overlapping patterns.
- WIN_LEN=1 is legal: WINDOW is a single cycle, then REPORT.

Optional Feature:
- Macro: DET_EDGE_MODE_EN.
- Defined:
  - An internal register holds det_in from the previous WINDOW cycle; it is cleared on rst and on entry to WINDOW.
  - evt_cnt increments only on a 0->1 transition of det_in within the window.
  - A det_in already high on the first window cycle counts as an edge.
- Not defined: every high cycle counts, as described above. No edge register is synthesised.

Test Plan (defaults unless stated):
1. rst pulse, then en=1 for one cycle, det_in=0 -> busy=1 for 17 cycles; count_valid pulses once 16 cycles after WINDOW entry; count_out=0, alarm=0; return to IDLE, busy=0.
2. en pulse; det_in=1 on window cycles 2, 5, 9 and 15 (the last cycle), all isolated -> count_out=4, alarm=1. det_in=1 during REPORT is not counted.
3. CNT_W=3, det_in=1 all 16 window cycles -> count_out=7 (saturated, no wrap), alarm=1.
4. en held high; window 1 has 4 pulses, window 2 has 2 pulses -> count_valid every 17 cycles; count_out 4 then 2; alarm 1 then 0.
5. en pulse, 2 det_in pulses, rst asserted on window cycle 6 -> next edge: all outputs 0, IDLE, no count_valid. Later det_in pulses ignored until en.
6. det_in high for 5 consecutive window cycles, else 0 -> count_out=5 without DET_EDGE_MODE_EN; count_out=1 with it.

Source files
------------

// File: rtl/det_window_counter.sv
// Counts upstream detector hits over fixed WIN_LEN-cycle windows and reports the count with a one-cycle strobe and an alarm.
// Optional DET_EDGE_MODE_EN: count only 0->1 transitions of det_in instead of every high cycle.
module det_window_counter #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 5,
    parameter int THRESH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det_in,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             alarm,
    output logic             busy
);
    localparam int               WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

    typedef enum logic [1:0] {IDLE, WINDOW, REPORT} state_t;

    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] evt_nxt;
    logic             hit;

`ifdef DET_EDGE_MODE_EN
    logic det_prev;

    // Held at 0 outside WINDOW so a level already high on the first window cycle counts as an edge.
    always_ff @(posedge clk) begin
        if (rst || state != WINDOW) det_prev <= 1'b0;
        else                        det_prev <= det_in;
    end

    assign hit = det_in & ~det_prev;
`else
    assign hit = det_in;
`endif

    // Saturating increment; also the value reported on the final window edge.
    assign evt_nxt = (hit && evt_cnt != CNT_MAX) ? evt_cnt + 1'b1 : evt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            win_cnt     <= '0;
            evt_cnt     <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
            alarm       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count_valid <= 1'b0;
                    win_cnt     <= '0;
                    evt_cnt     <= '0;
                    if (en) begin
                        state <= WINDOW;
                        busy  <= 1'b1;
                    end
                end
                WINDOW: begin
                    evt_cnt <= evt_nxt;
                    win_cnt <= win_cnt + 1'b1;
                    if (win_cnt == WIN_LAST) begin
                        state       <= REPORT;
                        count_valid <= 1'b1;
                        count_out   <= evt_nxt;
                        alarm       <= (evt_nxt >= THR);
                    end
                end
                REPORT: begin
                    count_valid <= 1'b0;
                    win_cnt     <= '0;
                    evt_cnt     <= '0;
                    if (en) begin
                        state <= WINDOW;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    count_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule
